// File: rtl/m_watch_gen.sv
// m_watch_gen: BCD real-time clock (24 h or 12 h) with a seconds view and digit-wise time setting.
// Build macro WATCH_BLINK_EN blinks the digit under edit while in SET.
module m_watch_gen #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned HOUR_24 = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_first_1,
  input  logic       key_first_2,
  input  logic       key_long_1,
  input  logic       key_long_2,
  output logic       next_mod,
  output logic [3:0] Hex_0,
  output logic [3:0] Hex_1,
  output logic [3:0] Hex_2,
  output logic [3:0] Hex_3,
  output logic       pm,
  output logic       setting,
  output logic [1:0] digit_sel
);

  localparam int unsigned   DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
  localparam bit            SUB_UNITS = (TICK_HZ != 10);
  localparam bit            H24       = (HOUR_24 != 0);

  typedef enum logic [1:0] {RUN, SEC_VIEW, SET} state_t;
  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic [3:0]    sub_t, sub_u, sec_t, sec_u, min_t, min_u, hr_t, hr_u;
  logic          pm_r;
  logic [1:0]    sel;
  logic          go_next, go_set, commit, inc, adv;
  logic          running, tick, sub_wrap, sec_wrap, min_wrap;
  logic [7:0]    hr12_next, hr_carry;
  logic [15:0]   disp;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d == lim) ? 4'd0 : d + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go_next  = 1'b0;
    go_set   = 1'b0;
    commit   = 1'b0;
    inc      = 1'b0;
    adv      = 1'b0;
    case (state)
      RUN: begin
        if (key_long_1)       go_next = 1'b1;
        else if (key_first_1) begin
          state_nx = SET;
          go_set   = 1'b1;
        end
        else if (key_long_2)  state_nx = SEC_VIEW;
      end
      SEC_VIEW: if (!key_long_2) state_nx = RUN;
      SET: begin
        if (key_long_1) begin
          commit   = 1'b1;
          state_nx = RUN;
        end else begin
          inc = key_first_2;
          adv = key_first_1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign running  = (state != SET);
  assign tick     = running && (presc == PRE_MAX);
  assign sub_wrap = tick && (sub_t == 4'd9) && (!SUB_UNITS || sub_u == 4'd9);
  assign sec_wrap = sub_wrap && (sec_t == 4'd5) && (sec_u == 4'd9);
  assign min_wrap = sec_wrap && (min_t == 4'd5) && (min_u == 4'd9);

  // 12 h hour sequence 12,01..11 shared by the carry chain and the SET hour key
  always_comb begin
    if ({hr_t, hr_u} == 8'h12)  hr12_next = 8'h01;
    else if (hr_u == 4'd9)      hr12_next = {hr_t + 4'd1, 4'd0};
    else                        hr12_next = {hr_t, hr_u + 4'd1};
    if (!H24)                   hr_carry  = hr12_next;
    else if ({hr_t, hr_u} == 8'h23) hr_carry = 8'h00;
    else if (hr_u == 4'd9)      hr_carry  = {hr_t + 4'd1, 4'd0};
    else                        hr_carry  = {hr_t, hr_u + 4'd1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sub_t    <= '0;
      sub_u    <= '0;
      sec_t    <= '0;
      sec_u    <= '0;
      min_t    <= '0;
      min_u    <= '0;
      hr_t     <= H24 ? 4'd0 : 4'd1;
      hr_u     <= H24 ? 4'd0 : 4'd2;
      pm_r     <= 1'b0;
      sel      <= '0;
      next_mod <= 1'b0;
    end else begin
      next_mod <= go_next;
      presc    <= (tick || !running) ? '0 : presc + 1'b1;
      if (go_set)   sel <= '0;
      else if (adv) sel <= sel + 2'd1;
      if (commit) begin
        sub_t <= '0;
        sub_u <= '0;
        sec_t <= '0;
        sec_u <= '0;
      end else if (tick) begin
        if (SUB_UNITS) begin
          sub_u <= bcd_inc(sub_u, 4'd9);
          if (sub_u == 4'd9) sub_t <= bcd_inc(sub_t, 4'd9);
        end else begin
          sub_t <= bcd_inc(sub_t, 4'd9);
        end
        if (sub_wrap) begin
          sec_u <= bcd_inc(sec_u, 4'd9);
          if (sec_u == 4'd9) sec_t <= bcd_inc(sec_t, 4'd5);
        end
        if (sec_wrap) begin
          min_u <= bcd_inc(min_u, 4'd9);
          if (min_u == 4'd9) min_t <= bcd_inc(min_t, 4'd5);
        end
        if (min_wrap) begin
          {hr_t, hr_u} <= hr_carry;
          if (!H24 && {hr_t, hr_u} == 8'h11) pm_r <= ~pm_r;
        end
      end else if (inc) begin
        case (sel)
          2'd0: min_u <= bcd_inc(min_u, 4'd9);
          2'd1: min_t <= bcd_inc(min_t, 4'd5);
          2'd2: begin
            if (H24) hr_u <= bcd_inc(hr_u, (hr_t == 4'd2) ? 4'd3 : 4'd9);
            else     {hr_t, hr_u} <= hr12_next;
          end
          default: begin
            // Moving hour tens to 2 clamps an out-of-range units digit in the same edge
            if (H24) begin
              hr_t <= bcd_inc(hr_t, 4'd2);
              if (hr_t == 4'd1 && hr_u > 4'd3) hr_u <= '0;
            end else begin
              pm_r <= ~pm_r;
            end
          end
        endcase
      end
    end
  end

`ifdef WATCH_BLINK_EN
  logic [PW-1:0] ph_pre;
  logic [3:0]    ph_t, ph_u;
  logic          ph_tick, blank;

  assign ph_tick = (ph_pre == PRE_MAX);
  assign blank   = (ph_t >= 4'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_pre <= '0;
      ph_t   <= '0;
      ph_u   <= '0;
    end else if (inc) begin
      ph_pre <= '0;
      ph_t   <= '0;
      ph_u   <= '0;
    end else begin
      ph_pre <= ph_tick ? '0 : ph_pre + 1'b1;
      if (ph_tick) begin
        if (SUB_UNITS) begin
          ph_u <= bcd_inc(ph_u, 4'd9);
          if (ph_u == 4'd9) ph_t <= bcd_inc(ph_t, 4'd9);
        end else begin
          ph_t <= bcd_inc(ph_t, 4'd9);
        end
      end
    end
  end
`endif

  always_comb begin
    disp = (state == SEC_VIEW) ? {sec_t, sec_u, sub_t, sub_u} : {hr_t, hr_u, min_t, min_u};
`ifdef WATCH_BLINK_EN
    if (state == SET && blank) disp[{sel, 2'b00} +: 4] = 4'hF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {Hex_3, Hex_2, Hex_1, Hex_0} <= '0;
    else        {Hex_3, Hex_2, Hex_1, Hex_0} <= disp;
  end

  assign pm        = H24 ? 1'b0 : pm_r;
  assign setting   = (state == SET);
  assign digit_sel = sel;

endmodule

// File: tb/tb_m_watch_gen.sv
// Bench for m_watch_gen: three instances (24 h, 12 h, 10 Hz tick) share the keys and are
// checked against a time-of-day model kept as integer centiseconds.
module tb_m_watch_gen;

  localparam int DIV    = 2;
  localparam int DAY    = 8640000;
  localparam int ST_RUN = 0;
  localparam int ST_SEC = 1;
  localparam int ST_SET = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kf1 = 1'b0, kf2 = 1'b0, kl1 = 1'b0, kl2 = 1'b0;
  logic [2:0][15:0] hx;
  logic [2:0]       nm, pmo, st;
  logic [2:0][1:0]  dsl;

  int vecs = 0;
  int errs = 0;

  int unsigned t [3];
  int          ms, pc, ds;
  logic [15:0] e_hex [3];
  logic        e_nm, e_set;
  logic [1:0]  e_ds;
  logic [2:0]  e_pm;

  always #5 clk = ~clk;

  m_watch_gen #(.CLK_HZ(200), .TICK_HZ(100), .HOUR_24(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .key_first_1(kf1), .key_first_2(kf2), .key_long_1(kl1),
    .key_long_2(kl2), .next_mod(nm[0]), .Hex_0(hx[0][3:0]), .Hex_1(hx[0][7:4]),
    .Hex_2(hx[0][11:8]), .Hex_3(hx[0][15:12]), .pm(pmo[0]), .setting(st[0]), .digit_sel(dsl[0]));

  m_watch_gen #(.CLK_HZ(200), .TICK_HZ(100), .HOUR_24(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .key_first_1(kf1), .key_first_2(kf2), .key_long_1(kl1),
    .key_long_2(kl2), .next_mod(nm[1]), .Hex_0(hx[1][3:0]), .Hex_1(hx[1][7:4]),
    .Hex_2(hx[1][11:8]), .Hex_3(hx[1][15:12]), .pm(pmo[1]), .setting(st[1]), .digit_sel(dsl[1]));

  m_watch_gen #(.CLK_HZ(20), .TICK_HZ(10), .HOUR_24(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .key_first_1(kf1), .key_first_2(kf2), .key_long_1(kl1),
    .key_long_2(kl2), .next_mod(nm[2]), .Hex_0(hx[2][3:0]), .Hex_1(hx[2][7:4]),
    .Hex_2(hx[2][11:8]), .Hex_3(hx[2][15:12]), .pm(pmo[2]), .setting(st[2]), .digit_sel(dsl[2]));

  function automatic int hr(int i);
    return t[i] / 360000;
  endfunction

  function automatic int mn(int i);
    return (t[i] / 6000) % 60;
  endfunction

  function automatic logic [15:0] disp(int i, int s, int unsigned tt);
    int a, b;
    if (s == ST_SEC) begin
      a = (tt / 100) % 60;
      b = tt % 100;
    end else begin
      a = tt / 360000;
      b = (tt / 6000) % 60;
      if (i == 1) a = (a % 12 == 0) ? 12 : a % 12;
    end
    return {4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10)};
  endfunction

  function automatic void edit(int i, int d);
    int h, m, rest, ht, hu;
    h = hr(i); m = mn(i); rest = t[i] % 6000;
    ht = h / 10; hu = h % 10;
    case (d)
      0: m = (m / 10) * 10 + ((m % 10 == 9) ? 0 : m % 10 + 1);
      1: m = ((m / 10 == 5) ? 0 : m / 10 + 1) * 10 + m % 10;
      2: begin
        if (i == 1) h = (h / 12) * 12 + (h % 12 + 1) % 12;
        else begin
          hu = (hu == ((ht == 2) ? 3 : 9)) ? 0 : hu + 1;
          h  = ht * 10 + hu;
        end
      end
      default: begin
        if (i == 1) h = (h + 12) % 24;
        else begin
          ht = (ht == 2) ? 0 : ht + 1;
          if (ht == 2 && hu > 3) hu = 0;
          h = ht * 10 + hu;
        end
      end
    endcase
    t[i] = h * 360000 + m * 6000 + rest;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) t[i] = 0;
    ms = ST_RUN; pc = 0; ds = 0;
  endfunction

  task automatic step();
    for (int i = 0; i < 3; i++) e_hex[i] = disp(i, ms, t[i]);
    e_nm = (ms == ST_RUN) && kl1;
    @(posedge clk);
    if (ms != ST_SET) begin
      if (pc == DIV - 1) begin
        pc = 0;
        for (int i = 0; i < 3; i++) t[i] = (t[i] + ((i == 2) ? 10 : 1)) % DAY;
      end else pc++;
    end else pc = 0;
    case (ms)
      ST_RUN: begin
        if (!kl1) begin
          if (kf1) begin ms = ST_SET; ds = 0; end
          else if (kl2) ms = ST_SEC;
        end
      end
      ST_SEC: if (!kl2) ms = ST_RUN;
      default: begin
        if (kl1) begin
          ms = ST_RUN; pc = 0;
          for (int i = 0; i < 3; i++) t[i] = t[i] - t[i] % 6000;
        end else begin
          if (kf2) for (int i = 0; i < 3; i++) edit(i, ds);
          if (kf1) ds = (ds + 1) % 4;
        end
      end
    endcase
    e_set = (ms == ST_SET);
    e_ds  = 2'(ds);
    for (int i = 0; i < 3; i++) e_pm[i] = (i == 1) && (hr(i) >= 12);
    #1;
  endtask

  task automatic press(input logic l1, input logic f1, input logic f2);
    kl1 = l1; kf1 = f1; kf2 = f2;
    step();
    kl1 = 1'b0; kf1 = 1'b0; kf2 = 1'b0;
  endtask

  task automatic goto_digit(int d);
    for (int n = 0; n < 4 && ds != d; n++) press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_time(int i, int th, int tm);
    if (i == 1) begin
      goto_digit(2);
      for (int n = 0; n < 12 && (hr(1) % 12 != th % 12); n++) press(1'b0, 1'b0, 1'b1);
      goto_digit(3);
      if ((hr(1) >= 12) != (th >= 12)) press(1'b0, 1'b0, 1'b1);
    end else begin
      goto_digit(3);
      for (int n = 0; n < 3 && hr(i) / 10 != 0; n++) press(1'b0, 1'b0, 1'b1);
      goto_digit(2);
      for (int n = 0; n < 10 && hr(i) % 10 != th % 10; n++) press(1'b0, 1'b0, 1'b1);
      goto_digit(3);
      for (int n = 0; n < 3 && hr(i) / 10 != th / 10; n++) press(1'b0, 1'b0, 1'b1);
    end
    goto_digit(1);
    for (int n = 0; n < 6 && mn(i) / 10 != tm / 10; n++) press(1'b0, 1'b0, 1'b1);
    goto_digit(0);
    for (int n = 0; n < 10 && mn(i) % 10 != tm % 10; n++) press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (hx[i] !== 16'h0000) begin errs++; $display("FAIL reset_hex%0d got %h exp 0000", i, hx[i]); end
    end
    vecs++; if (nm !== 3'b000)  begin errs++; $display("FAIL reset_next_mod got %b exp 000", nm); end
    vecs++; if (st !== 3'b000)  begin errs++; $display("FAIL reset_setting got %b exp 000", st); end
    vecs++; if (pmo !== 3'b000) begin errs++; $display("FAIL reset_pm got %b exp 000", pmo); end
    vecs++; if (dsl !== 6'd0)   begin errs++; $display("FAIL reset_digit_sel got %h exp 0", dsl); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      vecs++; if (hx[i] !== e_hex[i]) begin errs++; $display("FAIL post_reset_hex%0d got %h exp %h", i, hx[i], e_hex[i]); end
    end
    vecs++; if (hx[1] !== 16'h1200) begin errs++; $display("FAIL post_reset_12h got %h exp 1200", hx[1]); end
  endtask

  task automatic test_sec_view();
    kl2 = 1'b1;
    repeat (201) step();
    for (int i = 0; i < 3; i++) begin
      vecs++; if (hx[i] !== e_hex[i]) begin errs++; $display("FAIL sec_view_hex%0d got %h exp %h", i, hx[i], e_hex[i]); end
    end
    vecs++; if (hx[0] !== 16'h0100) begin errs++; $display("FAIL sec_view_1s got %h exp 0100", hx[0]); end
    kl2 = 1'b0;
    step();
    step();
    vecs++; if (hx[0] !== 16'h0000) begin errs++; $display("FAIL sec_view_back_run got %h exp 0000", hx[0]); end
    vecs++; if (hx[2] !== e_hex[2]) begin errs++; $display("FAIL sec_view_back_run_d2 got %h exp %h", hx[2], e_hex[2]); end
  endtask

  task automatic test_rollover_24h();
    press(1'b0, 1'b1, 1'b0);
    set_time(0, 23, 59);
    press(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 12001; c++) begin
      step();
      vecs++;
      if (hx[0] !== e_hex[0]) begin
        errs++;
        if (errs < 20) $display("FAIL rollover_hex0 cyc %0d got %h exp %h", c, hx[0], e_hex[0]);
      end
    end
    vecs++; if (hx[0] !== 16'h0000) begin errs++; $display("FAIL rollover_final got %h exp 0000", hx[0]); end
    vecs++; if (hx[1] !== e_hex[1]) begin errs++; $display("FAIL rollover_d1 got %h exp %h", hx[1], e_hex[1]); end
    vecs++; if (hx[2] !== e_hex[2]) begin errs++; $display("FAIL rollover_d2 got %h exp %h", hx[2], e_hex[2]); end
  endtask

  task automatic test_set_limits();
    logic [7:0] exp_hr [4];
    exp_hr = '{8'h21, 8'h22, 8'h23, 8'h20};
    press(1'b0, 1'b1, 1'b0);
    set_time(0, 17, 0);
    goto_digit(3);
    press(1'b0, 1'b0, 1'b1);
    step();
    vecs++; if (hx[0][15:8] !== 8'h20) begin errs++; $display("FAIL set_tens_force got %h exp 20", hx[0][15:8]); end
    vecs++; if (hx[0] !== e_hex[0]) begin errs++; $display("FAIL set_tens_model got %h exp %h", hx[0], e_hex[0]); end
    vecs++; if (hx[1] !== e_hex[1]) begin errs++; $display("FAIL set_pm_toggle_d1 got %h exp %h", hx[1], e_hex[1]); end
    goto_digit(2);
    for (int k = 0; k < 4; k++) begin
      press(1'b0, 1'b0, 1'b1);
      step();
      vecs++; if (hx[0][15:8] !== exp_hr[k]) begin errs++; $display("FAIL set_units_%0d got %h exp %h", k, hx[0][15:8], exp_hr[k]); end
      vecs++; if (hx[1] !== e_hex[1]) begin errs++; $display("FAIL set_12h_hour_%0d got %h exp %h", k, hx[1], e_hex[1]); end
    end
    vecs++; if (st !== 3'b111) begin errs++; $display("FAIL set_setting got %b exp 111", st); end
  endtask

  task automatic test_simultaneous();
    goto_digit(0);
    for (int n = 0; n < 10 && mn(0) % 10 != 9; n++) press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b1);
    vecs++; if (dsl[0] !== 2'd1) begin errs++; $display("FAIL simul_sel got %0d exp 1", dsl[0]); end
    vecs++; if (dsl[1] !== e_ds) begin errs++; $display("FAIL simul_sel_d1 got %0d exp %0d", dsl[1], e_ds); end
    step();
    vecs++; if (hx[0][3:0] !== 4'd0) begin errs++; $display("FAIL simul_min_units got %h exp 0", hx[0][3:0]); end
    vecs++; if (hx[0] !== e_hex[0]) begin errs++; $display("FAIL simul_model got %h exp %h", hx[0], e_hex[0]); end
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (st !== 3'b000) begin errs++; $display("FAIL commit_setting got %b exp 000", st); end
    vecs++; if (nm !== 3'b000) begin errs++; $display("FAIL commit_no_next_mod got %b exp 000", nm); end
  endtask

  task automatic test_12h();
    press(1'b0, 1'b1, 1'b0);
    set_time(1, 11, 59);
    step();
    vecs++; if (hx[1] !== 16'h1159) begin errs++; $display("FAIL h12_set got %h exp 1159", hx[1]); end
    vecs++; if (pmo[1] !== 1'b0) begin errs++; $display("FAIL h12_set_pm got %b exp 0", pmo[1]); end
    press(1'b1, 1'b0, 1'b0);
    repeat (12001) step();
    vecs++; if (hx[1] !== 16'h1200) begin errs++; $display("FAIL h12_roll got %h exp 1200", hx[1]); end
    vecs++; if (pmo !== e_pm) begin errs++; $display("FAIL h12_roll_pm got %b exp %b", pmo, e_pm); end
    vecs++; if (pmo[1] !== 1'b1) begin errs++; $display("FAIL h12_pm got %b exp 1", pmo[1]); end
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (nm !== 3'b111) begin errs++; $display("FAIL next_mod_pulse got %b exp 111", nm); end
    vecs++; if (st !== 3'b000) begin errs++; $display("FAIL next_mod_stay_run got %b exp 000", st); end
    step();
    vecs++; if (nm !== 3'b000) begin errs++; $display("FAIL next_mod_one_cycle got %b exp 000", nm); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      kf1 = ($urandom % 8) == 0;
      kf2 = ($urandom % 3) == 0;
      kl1 = ($urandom % 40) == 0;
      if (($urandom % 16) == 0) kl2 = ~kl2;
      step();
      kf1 = 1'b0; kf2 = 1'b0; kl1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
        vecs++; if (hx[i] !== e_hex[i]) begin errs++; if (errs < 20) $display("FAIL rand_hex%0d cyc %0d got %h exp %h", i, c, hx[i], e_hex[i]); end
        vecs++; if (pmo[i] !== e_pm[i]) begin errs++; if (errs < 20) $display("FAIL rand_pm%0d cyc %0d got %b exp %b", i, c, pmo[i], e_pm[i]); end
        vecs++; if (nm[i] !== e_nm) begin errs++; if (errs < 20) $display("FAIL rand_next_mod%0d cyc %0d got %b exp %b", i, c, nm[i], e_nm); end
        vecs++; if (st[i] !== e_set) begin errs++; if (errs < 20) $display("FAIL rand_setting%0d cyc %0d got %b exp %b", i, c, st[i], e_set); end
        vecs++; if (dsl[i] !== e_ds) begin errs++; if (errs < 20) $display("FAIL rand_sel%0d cyc %0d got %0d exp %0d", i, c, dsl[i], e_ds); end
      end
    end
    kl2 = 1'b0;
    step();
    if (ms == ST_SET) press(1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_set();
    press(1'b0, 1'b1, 1'b0);
    set_time(0, 15, 42);
    step();
    vecs++; if (hx[0] !== 16'h1542) begin errs++; $display("FAIL midset_edit got %h exp 1542", hx[0]); end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        vecs++; if (hx[i] !== 16'h0000) begin errs++; $display("FAIL midset_rst_hex%0d got %h exp 0000", i, hx[i]); end
      end
      vecs++; if ({nm, st, pmo} !== 9'd0) begin errs++; $display("FAIL midset_rst_flags got %b exp 0", {nm, st, pmo}); end
      vecs++; if (dsl !== 6'd0) begin errs++; $display("FAIL midset_rst_sel got %h exp 0", dsl); end
      repeat (2) @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    vecs++; if (hx[0] !== 16'h0000) begin errs++; $display("FAIL midset_after_hex0 got %h exp 0000", hx[0]); end
    vecs++; if (hx[1] !== 16'h1200) begin errs++; $display("FAIL midset_after_hex1 got %h exp 1200", hx[1]); end
    vecs++; if (st !== 3'b000) begin errs++; $display("FAIL midset_after_setting got %b exp 000", st); end
    step();
    vecs++; if (hx[0] !== e_hex[0]) begin errs++; $display("FAIL midset_running got %h exp %h", hx[0], e_hex[0]); end
  endtask

  initial begin
    test_reset();
    test_sec_view();
    test_rollover_24h();
    test_set_limits();
    test_simultaneous();
    test_12h();
    test_random();
    test_reset_mid_set();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
